// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group is resolved per
// register stage, with a single global advance for valid/ready flow control.
module cla_pipe_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    input  logic             Sub,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Carry,
    output logic             Ovf
);

    localparam int unsigned LAT = WIDTH / BLOCK;

    // Returns {carry into group MSB, group carry-out, group sum}; every carry is a flat
    // sum-of-products over g/p/cin, never a chain through the previous bit's carry.
    function automatic logic [BLOCK+1:0] cla_group(input logic [BLOCK-1:0] a,
                                                   input logic [BLOCK-1:0] b,
                                                   input logic             cin);
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] c;
        logic [BLOCK:1]   gen;
        logic             pp;
        logic             term;
        logic             cout;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        gen  = '0;
        pp   = 1'b1;
        for (int i = 0; i < int'(BLOCK); i++) begin
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                gen[i+1] = gen[i+1] | term;
            end
            pp = pp & p[i];
            if (i < int'(BLOCK) - 1) begin
                c[i+1] = gen[i+1] | (pp & cin);
            end
        end
        cout = gen[BLOCK] | (pp & cin);
        return {c[BLOCK-1], cout, p ^ c};
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_cond;
    logic             c_cond;
    logic             ovf_q;

    logic [LAT-1:0]   v_pipe;
    logic [LAT-1:0]   c_pipe;
    logic [WIDTH-1:0] a_pipe [LAT];
    logic [WIDTH-1:0] b_pipe [LAT];
    logic [WIDTH-1:0] s_pipe [LAT];

    assign adv      = ~Out_valid | Out_ready;
    assign In_ready = adv;
    assign b_cond   = Sub ? ~B : B;
    assign c_cond   = Sub ? ~C0 : C0;

    for (genvar k = 0; k < LAT; k++) begin : g_stage
        logic             v_in;
        logic             c_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic [WIDTH-1:0] s_d;
        logic [BLOCK+1:0] res;
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] s_q;

        if (k == 0) begin : g_head
            assign v_in = In_valid;
            assign c_in = c_cond;
            assign a_in = A;
            assign b_in = b_cond;
            assign s_in = '0;
        end else begin : g_body
            assign v_in = v_pipe[k-1];
            assign c_in = c_pipe[k-1];
            assign a_in = a_pipe[k-1];
            assign b_in = b_pipe[k-1];
            assign s_in = s_pipe[k-1];
        end

        assign res = cla_group(a_in[BLOCK*k +: BLOCK], b_in[BLOCK*k +: BLOCK], c_in);

        always_comb begin
            s_d                    = s_in;
            s_d[BLOCK*k +: BLOCK] = res[BLOCK-1:0];
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                c_q <= res[BLOCK];
                a_q <= a_in;
                b_q <= b_in;
                s_q <= s_d;
            end
        end

        assign v_pipe[k] = v_q;
        assign c_pipe[k] = c_q;
        assign a_pipe[k] = a_q;
        assign b_pipe[k] = b_q;
        assign s_pipe[k] = s_q;

        if (k == LAT - 1) begin : g_tail
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= res[BLOCK+1] ^ res[BLOCK];
                end
            end
        end
    end

    assign Out_valid = v_pipe[LAT-1];
    assign S         = s_pipe[LAT-1];
    assign Carry     = c_pipe[LAT-1];
    assign Ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder: a 16/4 instance for arithmetic, streaming, backpressure and
// reset, plus a 4/4 instance swept over every operand combination.
module tb_cla_pipe_adder;

    localparam int LAT = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        c0 = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] s;
    logic        carry;
    logic        ovf;

    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        c04 = 1'b0;
    logic        sub4 = 1'b0;
    logic        out_valid4;
    logic        out_ready4 = 1'b0;
    logic [3:0]  s4;
    logic        carry4;
    logic        ovf4;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    cla_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .CLK(CLK), .RST(RST), .In_valid(in_valid), .In_ready(in_ready), .A(a), .B(b),
        .C0(c0), .Sub(sub), .Out_valid(out_valid), .Out_ready(out_ready), .S(s),
        .Carry(carry), .Ovf(ovf)
    );

    cla_pipe_adder #(.WIDTH(4), .BLOCK(4)) dut4 (
        .CLK(CLK), .RST(RST), .In_valid(in_valid4), .In_ready(in_ready4), .A(a4), .B(b4),
        .C0(c04), .Sub(sub4), .Out_valid(out_valid4), .Out_ready(out_ready4), .S(s4),
        .Carry(carry4), .Ovf(ovf4)
    );

    // {ovf, carry, sum} from plain wide arithmetic and the signed-overflow rule
    function automatic logic [17:0] gold16(input logic [15:0] av, input logic [15:0] bv,
                                           input logic cv, input logic sv);
        logic [15:0] bb;
        logic [16:0] t;
        logic        cc;
        bb = sv ? ~bv : bv;
        cc = sv ? ~cv : cv;
        t  = {1'b0, av} + {1'b0, bb} + {16'd0, cc};
        return {(av[15] == bb[15]) && (t[15] != av[15]), t[16], t[15:0]};
    endfunction

    function automatic logic [5:0] gold4(input logic [3:0] av, input logic [3:0] bv,
                                         input logic cv, input logic sv);
        logic [3:0] bb;
        logic [4:0] t;
        logic       cc;
        bb = sv ? ~bv : bv;
        cc = sv ? ~cv : cv;
        t  = {1'b0, av} + {1'b0, bb} + {4'd0, cc};
        return {(av[3] == bb[3]) && (t[3] != av[3]), t[4], t[3:0]};
    endfunction

    task automatic drive16(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                           input logic sv);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        c0       = cv;
        sub      = sv;
    endtask

    // Issues one op on an empty pipe; returns at the negedge after edge accept+LAT-1.
    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                        input logic sv, output logic early_v);
        @(posedge CLK);
        #1;
        drive16(av, bv, cv, sv);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        repeat (LAT - 2) @(posedge CLK);
        @(negedge CLK);
        early_v = out_valid;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset;
        #3;
        RST = 1'b1;
        #1;
        tests++;
        if ({out_valid, in_ready, s, carry, ovf} !== {1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset16: got v=%b rdy=%b s=%h c=%b o=%b, want v=0 rdy=1 s=0000 c=0 o=0",
                     out_valid, in_ready, s, carry, ovf);
        end
        tests++;
        if ({out_valid4, in_ready4, s4, carry4, ovf4} !== {1'b0, 1'b1, 4'h0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset4: got v=%b rdy=%b s=%h c=%b o=%b, want v=0 rdy=1 s=0 c=0 o=0",
                     out_valid4, in_ready4, s4, carry4, ovf4);
        end
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RST        = 1'b0;
        out_ready  = 1'b1;
        out_ready4 = 1'b1;
    endtask

    task automatic test_add;
        logic ev;
        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, ev);
        tests++;
        if (ev !== 1'b0) begin
            fails++;
            $display("FAIL add_latency: valid one edge early got %b want 0", ev);
        end
        tests++;
        if ({out_valid, ovf, carry, s} !== {1'b1, 1'b0, 1'b1, 16'h0000}) begin
            fails++;
            $display("FAIL add_wrap: got v=%b o=%b c=%b s=%h want v=1 o=0 c=1 s=0000",
                     out_valid, ovf, carry, s);
        end
        op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, ev);
        tests++;
        if (ev !== 1'b0) begin
            fails++;
            $display("FAIL add_latency2: valid one edge early got %b want 0", ev);
        end
        tests++;
        if ({out_valid, ovf, carry, s} !== {1'b1, 1'b1, 1'b0, 16'h8000}) begin
            fails++;
            $display("FAIL add_ovf: got v=%b o=%b c=%b s=%h want v=1 o=1 c=0 s=8000",
                     out_valid, ovf, carry, s);
        end
    endtask

    task automatic test_sub;
        logic ev;
        op16(16'h8000, 16'h0001, 1'b0, 1'b1, ev);
        tests++;
        if ({ev, out_valid, ovf, carry, s} !== {1'b0, 1'b1, 1'b1, 1'b1, 16'h7FFF}) begin
            fails++;
            $display("FAIL sub_ovf: got ev=%b v=%b o=%b c=%b s=%h want ev=0 v=1 o=1 c=1 s=7fff",
                     ev, out_valid, ovf, carry, s);
        end
        op16(16'h0003, 16'h0005, 1'b1, 1'b1, ev);
        tests++;
        if ({ev, out_valid, ovf, carry, s} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFD}) begin
            fails++;
            $display("FAIL sub_borrow: got ev=%b v=%b o=%b c=%b s=%h want ev=0 v=1 o=0 c=0 s=fffd",
                     ev, out_valid, ovf, carry, s);
        end
        op16(16'h1234, 16'h0000, 1'b0, 1'b1, ev);
        tests++;
        if ({ev, out_valid, ovf, carry, s} !== {1'b0, 1'b1, 1'b0, 1'b1, 16'h1234}) begin
            fails++;
            $display("FAIL sub_zero: got ev=%b v=%b o=%b c=%b s=%h want ev=0 v=1 o=0 c=1 s=1234",
                     ev, out_valid, ovf, carry, s);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] ta [8];
        logic [15:0] tb [8];
        logic        tc [8];
        for (int i = 0; i < 8; i++) begin
            ta[i] = 16'(i * 16'h2345 + 16'h0F0F);
            tb[i] = 16'(16'hF00D - i * 16'h1111);
            tc[i] = 1'(i % 2);
        end
        @(posedge CLK);
        #1;
        for (int cyc = 0; cyc < 13; cyc++) begin
            if (cyc < 8) drive16(ta[cyc], tb[cyc], tc[cyc], 1'b0);
            else in_valid = 1'b0;
            @(negedge CLK);
            tests++;
            if (cyc >= 4 && cyc < 12) begin
                if ({out_valid, in_ready, ovf, carry, s} !==
                    {1'b1, 1'b1, gold16(ta[cyc-4], tb[cyc-4], tc[cyc-4], 1'b0)}) begin
                    fails++;
                    $display("FAIL stream_res%0d: got v=%b rdy=%b o=%b c=%b s=%h want %h",
                             cyc - 4, out_valid, in_ready, ovf, carry, s,
                             gold16(ta[cyc-4], tb[cyc-4], tc[cyc-4], 1'b0));
                end
            end else if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL stream_idle cyc%0d: got out_valid=%b want 0", cyc, out_valid);
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] pa [5];
        logic [15:0] pb [5];
        int          exp_idx;
        pa = '{16'h1111, 16'hA5A5, 16'h7FFF, 16'h0000, 16'hC000};
        pb = '{16'h2222, 16'h5A5A, 16'h7FFF, 16'hFFFF, 16'hC000};
        @(posedge CLK);
        #1;
        for (int cyc = 0; cyc < 13; cyc++) begin
            if (cyc < 4) begin
                out_ready = 1'b1;
                drive16(pa[cyc], pb[cyc], 1'b0, 1'b0);
            end else if (cyc < 7) begin
                out_ready = 1'b0;
                drive16(16'hDEAD, 16'hBEEF, 1'b1, 1'b0);
            end else if (cyc == 7) begin
                out_ready = 1'b1;
                drive16(pa[4], pb[4], 1'b0, 1'b0);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge CLK);
            tests++;
            if (cyc < 4 || cyc == 12) begin
                if ({out_valid, in_ready} !== 2'b01) begin
                    fails++;
                    $display("FAIL bp_idle cyc%0d: got v=%b rdy=%b want v=0 rdy=1",
                             cyc, out_valid, in_ready);
                end
            end else begin
                exp_idx = (cyc <= 7) ? 0 : cyc - 7;
                if ({out_valid, in_ready, ovf, carry, s} !==
                    {1'b1, (cyc > 6), gold16(pa[exp_idx], pb[exp_idx], 1'b0, 1'b0)}) begin
                    fails++;
                    $display("FAIL bp_res cyc%0d: got v=%b rdy=%b o=%b c=%b s=%h want rdy=%b %h",
                             cyc, out_valid, in_ready, ovf, carry, s, (cyc > 6),
                             gold16(pa[exp_idx], pb[exp_idx], 1'b0, 1'b0));
                end
            end
            @(posedge CLK);
            #1;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_exhaustive4;
        logic [9:0] v;
        logic [9:0] prev;
        prev = '0;
        @(posedge CLK);
        #1;
        for (int idx = 0; idx <= 1024; idx++) begin
            v = idx[9:0];
            if (idx < 1024) begin
                in_valid4 = 1'b1;
                sub4      = v[9];
                a4        = v[8:5];
                b4        = v[4:1];
                c04       = v[0];
            end else begin
                in_valid4 = 1'b0;
            end
            @(negedge CLK);
            if (idx > 0) begin
                tests++;
                if ({out_valid4, ovf4, carry4, s4} !==
                    {1'b1, gold4(prev[8:5], prev[4:1], prev[0], prev[9])}) begin
                    fails++;
                    $display("FAIL exh4 sub=%b a=%h b=%h c0=%b: got v=%b o=%b c=%b s=%h want %b",
                             prev[9], prev[8:5], prev[4:1], prev[0], out_valid4, ovf4, carry4,
                             s4, gold4(prev[8:5], prev[4:1], prev[0], prev[9]));
                end
            end
            prev = v;
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        tests++;
        if (out_valid4 !== 1'b0) begin
            fails++;
            $display("FAIL exh4_drain: got out_valid=%b want 0", out_valid4);
        end
    endtask

    task automatic test_reset_midflight;
        logic ev;
        @(posedge CLK);
        #1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (cyc < 3) drive16(16'h0100 * 16'(cyc + 1), 16'h0011, 1'b0, 1'b0);
            else in_valid = 1'b0;
            @(posedge CLK);
            #1;
        end
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL midflight_pre: got out_valid=%b want 1", out_valid);
        end
        #1;
        RST = 1'b1;
        #1;
        tests++;
        if ({out_valid, in_ready, s, carry, ovf} !== {1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL midflight_rst: got v=%b rdy=%b s=%h c=%b o=%b want v=0 rdy=1 s=0 c=0 o=0",
                     out_valid, in_ready, s, carry, ovf);
        end
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge CLK);
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL midflight_stale cyc%0d: got out_valid=%b want 0", cyc, out_valid);
            end
        end
        op16(16'h4321, 16'h1234, 1'b1, 1'b0, ev);
        tests++;
        if ({ev, out_valid, ovf, carry, s} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'h5556}) begin
            fails++;
            $display("FAIL midflight_next: got ev=%b v=%b o=%b c=%b s=%h want ev=0 v=1 o=0 c=0 s=5556",
                     ev, out_valid, ovf, carry, s);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_exhaustive4();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
